// File: rtl/io_request_arbiter_pkg.sv
// Shared types for the per-core I/O request arbiter.
// Packet layouts are common to cores, arbiter and peripheral bus.
package io_request_arbiter_pkg;

  localparam int NUM_CORES        = 4;
  localparam int THREADS_PER_CORE = 4;

  typedef logic [31:0] scalar_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
  typedef logic [3:0] core_id_t;

  typedef struct packed {
    logic        is_store;
    thread_idx_t thread_idx;
    scalar_t     address;
    scalar_t     value;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t    core;
    thread_idx_t thread_idx;
    scalar_t     read_value;
  } iorsp_packet_t;

endpackage

// File: rtl/io_request_arbiter_if.sv
// Peripheral I/O bus: one access per cycle,
// read data returns one cycle after read_en.
interface io_bus_interface;
  import io_request_arbiter_pkg::*;

  logic    write_en;
  logic    read_en;
  scalar_t address;
  scalar_t write_data;
  scalar_t read_data;

  modport master (
    output write_en,
    output read_en,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  address,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/io_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts
// after the last granted index and wraps around.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant
);

  localparam int IW =
    (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [IW-1:0]             last_q, last_d;
  logic [IW-1:0]             hi_idx, lo_idx;
  logic [NUM_REQUESTERS-1:0] hi_gnt, lo_gnt;
  logic                      hi_found, lo_found;

  // hi: first requester above the pointer; lo: first overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_gnt   = '0;
    lo_gnt   = '0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      if (request[j] && !hi_found && (IW'(j) > last_q)) begin
        hi_found  = 1'b1;
        hi_gnt[j] = 1'b1;
        hi_idx    = IW'(j);
      end
      if (request[j] && !lo_found) begin
        lo_found  = 1'b1;
        lo_gnt[j] = 1'b1;
        lo_idx    = IW'(j);
      end
    end
    grant  = hi_found ? hi_gnt : lo_gnt;
    last_d = last_q;
    if (update_lru && (hi_found || lo_found)) begin
      last_d = hi_found ? hi_idx : lo_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IW'(NUM_REQUESTERS - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/io_request_arbiter.sv
// Arbitrates per-core I/O requests onto one peripheral bus:
// grant at N, bus access at N+1, read data at N+2, response at N+3.
module io_request_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] ior_request_valid,
  input  ioreq_packet_t             ior_request [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] ior_request_ack,
  output logic                      ior_response_valid,
  output iorsp_packet_t             ior_response,
  io_bus_interface.master           io_bus
);

  logic [NUM_REQUESTERS-1:0] arb_req;
  logic [NUM_REQUESTERS-1:0] grant;
  ioreq_packet_t             sel_pkt;
  core_id_t                  sel_core;

  logic          s1_valid_q, s1_valid_d;
  ioreq_packet_t s1_req_q, s1_req_d;
  core_id_t      s1_core_q, s1_core_d;

  logic          s2_valid_q, s2_valid_d;
  logic          s2_store_q, s2_store_d;
  thread_idx_t   s2_thread_q, s2_thread_d;
  core_id_t      s2_core_q, s2_core_d;

  logic          rsp_valid_q, rsp_valid_d;
  iorsp_packet_t rsp_q, rsp_d;

  assign arb_req = ior_request_valid & {NUM_REQUESTERS{~reset}};

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .request   (arb_req),
    .update_lru(~reset),
    .grant     (grant)
  );

  assign ior_request_ack = grant;

  always_comb begin
    sel_pkt  = '0;
    sel_core = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) begin
        sel_pkt  = ior_request[i];
        sel_core = core_id_t'(i);
      end
    end
  end

  always_comb begin
    s1_valid_d  = |grant;
    s1_req_d    = sel_pkt;
    s1_core_d   = sel_core;
    s2_valid_d  = s1_valid_q;
    s2_store_d  = s1_req_q.is_store;
    s2_thread_d = s1_req_q.thread_idx;
    s2_core_d   = s1_core_q;
    rsp_valid_d = s2_valid_q;
    rsp_d       = '0;
    if (s2_valid_q) begin
      rsp_d.core       = s2_core_q;
      rsp_d.thread_idx = s2_thread_q;
      rsp_d.read_value = s2_store_q ? '0 : io_bus.read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s1_core_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_store_q  <= 1'b0;
      s2_thread_q <= '0;
      s2_core_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s1_core_q   <= s1_core_d;
      s2_valid_q  <= s2_valid_d;
      s2_store_q  <= s2_store_d;
      s2_thread_q <= s2_thread_d;
      s2_core_q   <= s2_core_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it
  assign io_bus.write_en   = ~reset & s1_valid_q & s1_req_q.is_store;
  assign io_bus.read_en    = ~reset & s1_valid_q & ~s1_req_q.is_store;
  assign io_bus.address    = reset ? '0 : s1_req_q.address;
  assign io_bus.write_data = reset ? '0 : s1_req_q.value;

  assign ior_response_valid = ~reset & rsp_valid_q;
  assign ior_response       = reset ? '0 : rsp_q;

endmodule

// File: tb/tb_io_request_arbiter.sv
// Bench for io_request_arbiter: vector table with
// response scoreboard, plus a 3-requester instance.
module tb_io_request_arbiter;
  import io_request_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  vld;
  ioreq_packet_t req [N];
  logic [N-1:0]  ack;
  logic          rv;
  iorsp_packet_t rsp;
  io_bus_interface bus ();

  logic          rst3;
  logic [2:0]    vld3;
  ioreq_packet_t req3 [3];
  logic [2:0]    ack3;
  logic          rv3;
  iorsp_packet_t rsp3;
  io_bus_interface bus3 ();

  io_request_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk               (clk),
    .reset             (rst),
    .ior_request_valid (vld),
    .ior_request       (req),
    .ior_request_ack   (ack),
    .ior_response_valid(rv),
    .ior_response      (rsp),
    .io_bus            (bus)
  );

  io_request_arbiter #(.NUM_REQUESTERS(3)) dut3 (
    .clk               (clk),
    .reset             (rst3),
    .ior_request_valid (vld3),
    .ior_request       (req3),
    .ior_request_ack   (ack3),
    .ior_response_valid(rv3),
    .ior_response      (rsp3),
    .io_bus            (bus3)
  );

  function automatic scalar_t data_for(scalar_t a);
    return (a == 32'hFFFF0004) ? 32'h12345678 : (a ^ 32'hC0DE0000);
  endfunction

  // Peripheral model: data only in the cycle after read_en
  always @(posedge clk) begin
    bus.read_data  <= bus.read_en ? data_for(bus.address) : 32'hBAD0BAD0;
    bus3.read_data <= bus3.read_en ? data_for(bus3.address) : 32'hBAD0BAD0;
  end

  function automatic ioreq_packet_t gen_pkt(int k, int r);
    ioreq_packet_t p;
    p.is_store   = ((k + r) % 3) == 0;
    p.thread_idx = thread_idx_t'((k + r) % 4);
    p.address    = 32'hFFFF1000 + scalar_t'(k * 16 + r * 4);
    p.value      = 32'h5A5A0000 ^ scalar_t'(k * 256 + r);
    return p;
  endfunction

  typedef struct {
    logic          rst;
    logic [N-1:0]  v;
    logic [N-1:0]  ack;
    logic          use_pkt;
    ioreq_packet_t pkt;
  } vec_t;

  typedef struct {
    int      due;
    logic    we;
    logic    re;
    scalar_t addr;
    scalar_t data;
  } bus_exp_t;

  typedef struct {
    int            due;
    iorsp_packet_t r;
  } rsp_exp_t;

  vec_t     vt [$];
  bus_exp_t bq [$];
  rsp_exp_t rq [$];
  int       cyc = 0;
  int       n_chk = 0;
  int       n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic [N-1:0] v, logic [N-1:0] a);
    vec_t e;
    e.rst = r;
    e.v = v;
    e.ack = a;
    e.use_pkt = 1'b0;
    e.pkt = '0;
    return e;
  endfunction

  function automatic vec_t mkp(logic [N-1:0] v, logic [N-1:0] a,
                               logic st, thread_idx_t t,
                               scalar_t ad, scalar_t val);
    vec_t e;
    e = mk(1'b0, v, a);
    e.use_pkt = 1'b1;
    e.pkt.is_store = st;
    e.pkt.thread_idx = t;
    e.pkt.address = ad;
    e.pkt.value = val;
    return e;
  endfunction

  task automatic check_outputs();
    bus_exp_t b;
    rsp_exp_t e;
    if (rst) begin
      chk("rst_we", bus.write_en, 0);
      chk("rst_re", bus.read_en, 0);
      chk("rst_addr", bus.address, 0);
      chk("rst_wdata", bus.write_data, 0);
      chk("rst_rv", rv, 0);
      chk("rst_rsp", rsp, 0);
      bq.delete();
      rq.delete();
      return;
    end
    chk("we_re_excl", bus.write_en & bus.read_en, 0);
    if (bq.size() > 0 && bq[0].due == cyc) begin
      b = bq.pop_front();
      chk("bus_we", bus.write_en, b.we);
      chk("bus_re", bus.read_en, b.re);
      chk("bus_addr", bus.address, b.addr);
      chk("bus_wdata", bus.write_data, b.data);
    end else begin
      chk("idle_en", {bus.write_en, bus.read_en}, 0);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      chk("rsp_valid", rv, 1);
      chk("rsp_pkt", rsp, e.r);
    end else begin
      chk("rsp_idle", rv, 0);
    end
  endtask

  task automatic step(input vec_t v, input int k);
    ioreq_packet_t p;
    bus_exp_t      b;
    rsp_exp_t      e;
    @(posedge clk);
    #1;
    rst = v.rst;
    vld = v.v;
    for (int r = 0; r < N; r++) req[r] = v.use_pkt ? v.pkt : gen_pkt(k, r);
    @(negedge clk);
    check_outputs();
    chk("ack", ack, v.ack);
    for (int r = 0; r < N; r++) begin
      if (v.ack[r]) begin
        p = req[r];
        b.due = cyc + 1;
        b.we = p.is_store;
        b.re = !p.is_store;
        b.addr = p.address;
        b.data = p.value;
        bq.push_back(b);
        e.due = cyc + 3;
        e.r.core = core_id_t'(r);
        e.r.thread_idx = p.thread_idx;
        e.r.read_value = p.is_store ? '0 : data_for(p.address);
        rq.push_back(e);
      end
    end
    cyc++;
  endtask

  initial begin
    int c3;
    int k3;
    int exp3 [$];
    int due3 [$];
    logic [2:0] a3 [4];
    rst = 1'b1;
    vld = '0;
    for (int r = 0; r < N; r++) req[r] = '0;
    rst3 = 1'b1;
    vld3 = '0;
    for (int r = 0; r < 3; r++) req3[r] = '0;

    vt.push_back(mk(1, 4'b0000, 4'b0000));
    vt.push_back(mk(1, 4'b0000, 4'b0000));
    vt.push_back(mkp(4'b0100, 4'b0100, 0, 2'd1, 32'hFFFF0004, 32'h0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 0));
    vt.push_back(mkp(4'b0001, 4'b0001, 1, 2'd0, 32'hFFFF0020, 32'hDEADBEEF));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 0));
    vt.push_back(mk(1, 4'b0000, 4'b0000));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 4'b1111, 4'(1 << (i % 4))));
    vt.push_back(mk(0, 4'b1010, 4'b0010));
    vt.push_back(mk(0, 4'b1010, 4'b1000));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 0));
    vt.push_back(mk(0, 4'b0110, 4'b0010));
    vt.push_back(mk(0, 0, 0));
    vt.push_back(mk(0, 4'b0110, 4'b0100));
    vt.push_back(mk(0, 4'b1001, 4'b1000));
    vt.push_back(mk(0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0001));
    vt.push_back(mk(0, 4'b1111, 4'b0010));
    vt.push_back(mk(0, 4'b1111, 4'b0100));
    vt.push_back(mk(1, 4'b1111, 4'b0000));
    vt.push_back(mk(0, 4'b1111, 4'b0001));
    for (int i = 0; i < 5; i++) vt.push_back(mk(0, 0, 0));

    for (int i = 0; i < vt.size(); i++) step(vt[i], i);
    chk("bus_queue_drained", bq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);

    // Three requesters: wrap must skip the non-existent index 3
    a3[0] = 3'b001;
    a3[1] = 3'b010;
    a3[2] = 3'b100;
    a3[3] = 3'b001;
    c3 = 0;
    for (k3 = 0; k3 < 10; k3++) begin
      @(posedge clk);
      #1;
      rst3 = (k3 == 0);
      vld3 = (k3 >= 1 && k3 <= 4) ? 3'b111 : 3'b000;
      for (int r = 0; r < 3; r++) req3[r] = gen_pkt(k3 + 40, r);
      @(negedge clk);
      if (k3 >= 1 && k3 <= 4) begin
        chk("ack3", ack3, a3[k3-1]);
        exp3.push_back((k3 - 1) % 3);
        due3.push_back(k3 + 3);
      end else begin
        chk("ack3_idle", ack3, 0);
      end
      if (due3.size() > 0 && due3[0] == k3) begin
        chk("rsp3_valid", rv3, 1);
        chk("rsp3_core", rsp3.core, core_id_t'(exp3[0]));
        chk("rsp3_range", rsp3.core < 4'd3, 1);
        void'(due3.pop_front());
        void'(exp3.pop_front());
        c3++;
      end else begin
        chk("rsp3_idle", rv3, 0);
      end
    end
    chk("rsp3_count", c3, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
